// File: rtl/mips_pkg.sv
// Shared pipeline constants: data-memory operation codes and the default
// data-memory depth, imported by the decoder, pipeline registers and dm_stage.
package mips_pkg;

    localparam int unsigned DM_DEPTH = 3072;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LW   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LHU  = 4'd3,
        MEM_LB   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_SW   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SB   = 4'd8
    } mem_op_e;

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
               (op == MEM_LB) || (op == MEM_LBU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension; any non-load op yields zero.
module dm_load_ext
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  mem_op_e     op,
    output logic [31:0] rdata
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = lane[1] ? word[31:16] : word[15:0];
        byte_sel = word[8*lane +: 8];
        rdata    = '0;
        unique case (op)
            MEM_LW:  rdata = word;
            MEM_LH:  rdata = {{16{half[15]}}, half};
            MEM_LHU: rdata = {16'h0000, half};
            MEM_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: rdata = {24'h000000, byte_sel};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// Data memory stage: word-addressed RAM with async sign/zero-extended loads,
// byte-enabled synchronous stores, and misalignment/range error flagging.
module dm_stage
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH,
    parameter int unsigned AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_err
);

    logic [31:0] mem [DEPTH];

    mem_op_e     op;
    mem_op_e     ext_op;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic        in_range;
    logic        misaligned;
    logic        access;
    logic        store_en;
    logic [3:0]  be;
    logic [31:0] wdata_al;
    logic [31:0] word;

    always_comb begin
        // Codes 9-15 fold onto NONE before any decoding.
        op         = (mem_op > 4'd8) ? MEM_NONE : mem_op_e'(mem_op);
        idx        = addr[AW+1:2];
        lane       = addr[1:0];
        in_range   = addr < (32'(DEPTH) << 2);
        misaligned = 1'b0;
        unique case (op)
            MEM_LW, MEM_SW:          misaligned = (addr[1:0] != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: misaligned = addr[0];
            default:                 misaligned = 1'b0;
        endcase
        access   = valid && (is_load(op) || is_store(op));
        addr_err = access && (!in_range || misaligned);
        store_en = access && is_store(op) && !addr_err;
        ext_op   = (valid && !addr_err) ? op : MEM_NONE;
        word     = in_range ? mem[idx] : '0;
    end

    always_comb begin
        be       = '0;
        wdata_al = wdata;
        unique case (op)
            MEM_SW: begin
                be       = '1;
                wdata_al = wdata;
            end
            MEM_SH: begin
                be       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            MEM_SB: begin
                be       = 4'b0001 << lane;
                wdata_al = {4{wdata[7:0]}};
            end
            default: begin
                be       = '0;
                wdata_al = wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (store_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

    dm_load_ext u_load_ext (
        .word  (word),
        .lane  (lane),
        .op    (ext_op),
        .rdata (rdata)
    );

endmodule

// File: doc/dm_stage.md
# dm_stage

Data memory stage of the five-stage pipeline. Sits between the E-to-M pipeline register and the M-to-W pipeline register. Performs word/half/byte loads with sign or zero extension and byte-enabled stores into an internal word-addressed RAM. Flags misaligned and out-of-range accesses. The load result is presented combinationally so the M-to-W register captures it as `DM_data_out` on the same edge.

## Interface
Parameters:
- DEPTH, 3072, number of 32-bit words (12 KiB); valid byte addresses are 0 .. 4*DEPTH-1.
- AW, 12, word-index width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  pipeline clock; single clock domain, all state updates on posedge.
- reset  input  1  synchronous, active-high; clears the entire RAM on the next posedge.
- valid  input  1  M-stage instruction is live; when 0, nothing is written and no error is flagged.
- mem_op  input  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; codes 9-15 are treated as NONE.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rt value after forwarding); right-aligned for SH/SB.
- rdata  output  32  extended load result; 0 for NONE, stores, and errored accesses.
- addr_err  output  1  access is misaligned or out of range; combinational.

## Operation
- Word index is addr[AW+1:2]; byte lane is addr[1:0].
- Range check: addr >= 4*DEPTH is out of range.
- Alignment check: LW/SW need addr[1:0]==0; LH/LHU/SH need addr[0]==0. Byte accesses are always aligned.
- addr_err = valid & (load or store) & (out of range | misaligned).
- Loads (async read of mem[idx]):
  - LW returns the word.
  - LH/LHU select half addr[1] (1 = bits 31:16) and sign/zero-extend.
  - LB/LBU select byte addr[1:0] (3 = bits 31:24) and sign/zero-extend.
- Stores commit at posedge when valid & store & !addr_err & !reset, using byte-enables:
  - SW: 4'b1111, whole wdata.
  - SH: 4'b0011 or 4'b1100 per addr[1], taking wdata[15:0].
  - SB: one-hot per addr[1:0], taking wdata[7:0].
  - Unenabled bytes keep their previous value.
- Errored accesses never modify memory; rdata is 0.

## Timing
- Load latency 0 cycles: rdata is valid in the same cycle as addr and mem_op.
- Store latency 1 cycle: visible to a load issued in the following cycle.
- Same-cycle read and write to the same word: the load sees the pre-store contents. There is no internal bypass; the pipeline never issues both at once.
- Reset cycle: any store presented is dropped; after the edge every word is 0, so any load returns 0. rdata and addr_err have no registers; both are 0 whenever valid=0.
- Back-to-back stores to the same word in consecutive cycles merge byte-wise in order.
- Top word (idx DEPTH-1) is writable; the first byte past it errors.
- mem_op and addr may change every cycle. The block holds no state besides the RAM and needs no stall handshake: the upstream register holds inputs during stalls, and valid is deasserted for bubbles so a stalled store is written exactly once.

## Structure
- Shared package `mips_pkg` holds the MEM_* op constants (NONE..SB) and the DEPTH default. The decoder and the pipeline registers import the same constants.
- One sub-module, `dm_load_ext`, is combinational lane select plus sign/zero extension: inputs word, lane, op; output rdata.
- Store byte-enable generation and the RAM array stay in `dm_stage`.

## Test plan
- Reset, then LW at 0x0, 0x4, 0x2FFC -> rdata=0, addr_err=0.
- SW 0x8000_00FF at 0x10. Next cycle: LW 0x10 -> 0x8000_00FF; LB 0x13 -> 0xFFFF_FF80; LBU 0x13 -> 0x0000_0080; LH 0x12 -> 0xFFFF_8000; LHU 0x10 -> 0x0000_00FF.
- SW 0 at 0x20, then SB 0xAB at 0x21, then SH 0x1234 at 0x22 -> LW 0x20 = 0x1234_AB00.
- SW at 0x22, LH at 0x11, LW at 0x3000 -> addr_err=1, rdata=0, memory unchanged (LW 0x20 still 0x1234_AB00).
- Store with valid=0 at 0x30 (wdata 0xDEAD_BEEF) -> LW 0x30 = 0. SW 0x5555_5555 at 0x30 in the same cycle as reset=1 -> LW 0x30 = 0 afterwards.
- SW 0x1111_1111 at 0x40 with a simultaneous LW 0x40 in the same cycle -> that cycle's rdata is the old value (0); next cycle LW 0x40 = 0x1111_1111.
